// File: rtl/pc_fetch_ctrl.sv
// PC ownership and instruction fetch sequencing for the MIPS core.
// Optional fetch watchdog enabled by defining IMEM_TIMEOUT_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | first cycle out of reset, no request yet
// FETCH  | request issued at pc, ack may return this cycle
// WAIT   | request held stable until ack (or watchdog expiry)
// EXEC   | instruction presented to datapath, commit unless blocked
// HALTED | parked, no requests; only reset leaves this state
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
`ifdef IMEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [29:0] pc,
    input  logic [29:0] npc,
    input  logic        stall,
    input  logic        exc,
    input  logic        halt,
    output logic [31:0] inst_cnt,
    output logic        fetch_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       tmo_hit;

    assign imem_req    = (state == S_FETCH) || (state == S_WAIT);
    assign imem_addr   = imem_req ? pc : 30'h0;
    assign instr_valid = (state == S_EXEC) & ~stall & ~exc & ~halt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH, S_WAIT: begin
                if (imem_ack)     state_nxt = S_EXEC;
                else if (tmo_hit) state_nxt = S_HALTED;
                else              state_nxt = S_WAIT;
            end
            S_EXEC: begin
                if (exc)         state_nxt = S_FETCH;
                else if (halt)   state_nxt = S_HALTED;
                else if (!stall) state_nxt = S_FETCH;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC[31:2];
            instr    <= 32'h0;
            inst_cnt <= 32'h0;
        end else begin
            state <= state_nxt;
            if (imem_req && imem_ack)
                instr <= imem_rdata;
            if (state == S_EXEC) begin
                if (exc) begin
                    pc <= EXC_VEC[31:2];
                end else if (!halt && !stall) begin
                    pc       <= npc;
                    inst_cnt <= inst_cnt + 32'd1;
                end
            end
        end
    end

`ifdef IMEM_TIMEOUT_EN
    // Down-counter reloaded on every entry to FETCH; terminal count at zero
    // marks the TIMEOUT_CYC-th unacknowledged request cycle.
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC - 1);

    logic [15:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == 16'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= TMO_LOAD;
            fetch_err <= 1'b0;
        end else begin
            if (state_nxt == S_FETCH)
                tmo_cnt <= TMO_LOAD;
            else if (imem_req && !imem_ack && !tmo_hit)
                tmo_cnt <= tmo_cnt - 16'd1;
            if (imem_req && !imem_ack && tmo_hit)
                fetch_err <= 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: per-cycle vector table plus hand-written
// sequences for halt parking, reset during WAIT and the fetch watchdog.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [29:0] pc;
    logic [29:0] npc;
    logic        stall;
    logic        exc;
    logic        halt;
    logic [31:0] inst_cnt;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .npc         (npc),
        .stall       (stall),
        .exc         (exc),
        .halt        (halt),
        .inst_cnt    (inst_cnt),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic [29:0] npc;
        logic        stall;
        logic        exc;
        logic        halt;
        logic        req;
        logic [29:0] addr;
        logic        valid;
        logic [29:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } vec_t;

    localparam int NV = 24;
    vec_t vt[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic a, input logic [31:0] d, input logic [29:0] n,
                          input logic s, input logic e, input logic h);
        imem_ack   = a;
        imem_rdata = d;
        npc        = n;
        stall      = s;
        exc        = e;
        halt       = h;
    endtask

    int req_cyc;

    initial begin
        //        ack   rdata          npc        stl   exc   hlt  | req   addr       vld   pc         instr          cnt
        vt[0]  = '{1'b1, 32'hDEAD_BEEF, 30'h0C01, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b0, 30'h0C00, 32'h0000_0000, 32'd0};
        vt[1]  = '{1'b1, 32'h1111_0000, 30'h0C01, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C00, 1'b0, 30'h0C00, 32'h0000_0000, 32'd0};
        vt[2]  = '{1'b0, 32'h0000_0000, 30'h0C01, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b1, 30'h0C00, 32'h1111_0000, 32'd0};
        vt[3]  = '{1'b1, 32'h1111_0001, 30'h0C02, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C01, 1'b0, 30'h0C01, 32'h1111_0000, 32'd1};
        vt[4]  = '{1'b0, 32'h0000_0000, 30'h0C02, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b1, 30'h0C01, 32'h1111_0001, 32'd1};
        vt[5]  = '{1'b1, 32'h1111_0002, 30'h0C03, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C02, 1'b0, 30'h0C02, 32'h1111_0001, 32'd2};
        vt[6]  = '{1'b0, 32'h0000_0000, 30'h0C03, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b1, 30'h0C02, 32'h1111_0002, 32'd2};
        vt[7]  = '{1'b1, 32'h1111_0003, 30'h0C04, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C03, 1'b0, 30'h0C03, 32'h1111_0002, 32'd3};
        vt[8]  = '{1'b0, 32'h0000_0000, 30'h0C04, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b1, 30'h0C03, 32'h1111_0003, 32'd3};
        // delayed ack: request held four cycles
        vt[9]  = '{1'b0, 32'hAAAA_0000, 30'h0C05, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C04, 1'b0, 30'h0C04, 32'h1111_0003, 32'd4};
        vt[10] = '{1'b0, 32'hAAAA_0001, 30'h0C05, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C04, 1'b0, 30'h0C04, 32'h1111_0003, 32'd4};
        vt[11] = '{1'b0, 32'hAAAA_0002, 30'h0C05, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C04, 1'b0, 30'h0C04, 32'h1111_0003, 32'd4};
        vt[12] = '{1'b1, 32'h1234_5678, 30'h0C05, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C04, 1'b0, 30'h0C04, 32'h1111_0003, 32'd4};
        vt[13] = '{1'b0, 32'h0000_0000, 30'h0C05, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b1, 30'h0C04, 32'h1234_5678, 32'd4};
        // stall for two EXEC cycles
        vt[14] = '{1'b1, 32'h5555_AAAA, 30'h0C06, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C05, 1'b0, 30'h0C05, 32'h1234_5678, 32'd5};
        vt[15] = '{1'b1, 32'hBAD0_0001, 30'h0C06, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b0, 30'h0C05, 32'h5555_AAAA, 32'd5};
        vt[16] = '{1'b0, 32'h0000_0000, 30'h0C06, 1'b1, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b0, 30'h0C05, 32'h5555_AAAA, 32'd5};
        vt[17] = '{1'b0, 32'h0000_0000, 30'h0C06, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0000, 1'b1, 30'h0C05, 32'h5555_AAAA, 32'd5};
        // exc and halt together: exception wins
        vt[18] = '{1'b1, 32'h6666_0000, 30'h0C07, 1'b0, 1'b0, 1'b0, 1'b1, 30'h0C06, 1'b0, 30'h0C06, 32'h5555_AAAA, 32'd6};
        vt[19] = '{1'b0, 32'h0000_0000, 30'h0C07, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0000, 1'b0, 30'h0C06, 32'h6666_0000, 32'd6};
        vt[20] = '{1'b0, 32'h0000_0000, 30'h1061, 1'b0, 1'b0, 1'b0, 1'b1, 30'h1060, 1'b0, 30'h1060, 32'h6666_0000, 32'd6};
        vt[21] = '{1'b1, 32'h7777_0001, 30'h1061, 1'b0, 1'b0, 1'b0, 1'b1, 30'h1060, 1'b0, 30'h1060, 32'h6666_0000, 32'd6};
        // halt alone, then HALTED ignores everything
        vt[22] = '{1'b0, 32'h0000_0000, 30'h1061, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0000, 1'b0, 30'h1060, 32'h7777_0001, 32'd6};
        vt[23] = '{1'b1, 32'hBAD0_0002, 30'h0155, 1'b0, 1'b1, 1'b0, 1'b0, 30'h0000, 1'b0, 30'h1060, 32'h7777_0001, 32'd6};

        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 30'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", {2'b0, pc}, 32'h0000_0C00);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_cnt", inst_cnt, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_in(vt[i].ack, vt[i].rdata, vt[i].npc, vt[i].stall, vt[i].exc, vt[i].halt);
            @(negedge clk);
            check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vt[i].req});
            check($sformatf("v%0d_addr", i), {2'b0, imem_addr}, {2'b0, vt[i].addr});
            check($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vt[i].valid});
            check($sformatf("v%0d_pc", i), {2'b0, pc}, {2'b0, vt[i].pc});
            check($sformatf("v%0d_instr", i), instr, vt[i].instr);
            check($sformatf("v%0d_cnt", i), inst_cnt, vt[i].cnt);
            check($sformatf("v%0d_err", i), {31'b0, fetch_err}, 32'd0);
            @(posedge clk);
            #1;
        end

        // HALTED holds for 20 cycles under random stimulus
        for (int k = 0; k < 20; k++) begin
            set_in(1'($urandom_range(0, 1)), $urandom, 30'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            check($sformatf("halted%0d_req", k), {31'b0, imem_req}, 32'd0);
            check($sformatf("halted%0d_valid", k), {31'b0, instr_valid}, 32'd0);
            check($sformatf("halted%0d_pc", k), {2'b0, pc}, 32'h0000_1060);
            @(posedge clk);
            #1;
        end
        check("halted_instr", instr, 32'h7777_0001);
        check("halted_cnt", inst_cnt, 32'd6);

        // reset asserted mid-WAIT with an ack arriving: request drops, ack lost
        set_in(1'b0, 32'h0, 30'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("wait_req", {31'b0, imem_req}, 32'd1);
        check("wait_addr", {2'b0, imem_addr}, 32'h0000_0C00);
        #2;
        set_in(1'b1, 32'hBAD0_0003, 30'h0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("rstwait_req", {31'b0, imem_req}, 32'd0);
        check("rstwait_addr", {2'b0, imem_addr}, 32'd0);
        @(posedge clk);
        #1;
        check("rstwait_instr", instr, 32'd0);
        check("rstwait_pc", {2'b0, pc}, 32'h0000_0C00);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("idle_req", {31'b0, imem_req}, 32'd0);
        @(posedge clk);
        #1;

        // ack never returns: count request cycles
        req_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (imem_req) req_cyc++;
            @(posedge clk);
            #1;
        end
`ifdef IMEM_TIMEOUT_EN
        check("tmo_req_cycles", 32'(req_cyc), 32'd16);
        check("tmo_err", {31'b0, fetch_err}, 32'd1);
        check("tmo_req_low", {31'b0, imem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("tmo_err_cleared", {31'b0, fetch_err}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
`else
        check("notmo_req_cycles", 32'(req_cyc), 32'd40);
        check("notmo_err", {31'b0, fetch_err}, 32'd0);
        check("notmo_req_high", {31'b0, imem_req}, 32'd1);
        check("notmo_addr", {2'b0, imem_addr}, 32'h0000_0C00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
